// File: rtl/uart_rx_buffer.sv
// Receive-side character buffer for a UART: FIFO or single holding register,
// with overrun, error summary, trigger level and character-timeout reporting.
module uart_rx_buffer #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          cfg_fifo_en_i,
    input  logic [1:0]                    cfg_trigger_i,
    input  logic [DIV_WIDTH-1:0]          cfg_div_i,
    input  logic [3:0]                    cfg_frame_bits_i,
    input  logic                          clr_i,
    input  logic                          rx_valid_i,
    input  logic [7:0]                    rx_data_i,
    input  logic [2:0]                    rx_err_i,
    input  logic                          pop_i,
    input  logic                          ovr_clr_i,
    output logic                          valid_o,
    output logic [7:0]                    data_o,
    output logic [2:0]                    err_o,
    output logic [$clog2(FIFO_DEPTH):0]   elements_o,
    output logic                          overrun_o,
    output logic                          fifo_err_o,
    output logic                          trigger_o,
    output logic                          timeout_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LVL_1  = CW'(1);
    localparam logic [CW-1:0] LVL_Q  = CW'(FIFO_DEPTH / 4);
    localparam logic [CW-1:0] LVL_H  = CW'(FIFO_DEPTH / 2);
    localparam logic [CW-1:0] LVL_M2 = CW'(FIFO_DEPTH - 2);
    localparam logic [5:0]    BT_MAX = 6'd48;

    logic [10:0]          r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_rd_ptr, r_wr_ptr;
    logic [CW-1:0]        r_count, r_err_cnt;
    logic                 r_overrun, r_timeout;
    logic                 r_en_q, r_en_vld;
    logic [DIV_WIDTH-1:0] r_pre;
    logic [5:0]           r_bt;

    logic [CW-1:0]        w_eff_depth, w_lvl;
    logic [10:0]          w_head;
    logic                 w_flush, w_valid, w_head_err, w_new_err;
    logic                 w_pop, w_push, w_full, w_ovr_evt, w_ovwr, w_acc;
    logic                 w_err_inc, w_err_dec, w_tmr_rst, w_tick;
    logic [DIV_WIDTH-1:0] w_pre_nxt;
    logic [5:0]           w_bt_nxt, w_thr;

    // A mode switch is treated as a flush; r_en_vld masks the first edge after reset.
    assign w_flush     = clr_i | (r_en_vld & (cfg_fifo_en_i != r_en_q));
    assign w_eff_depth = cfg_fifo_en_i ? CW'(FIFO_DEPTH) : CW'(1);
    assign w_valid     = (r_count != '0);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_err  = |w_head[10:8];
    assign w_new_err   = |rx_err_i;
    assign w_pop       = pop_i & w_valid & ~w_flush;
    assign w_push      = rx_valid_i & ~w_flush;
    assign w_full      = (r_count >= w_eff_depth);
    assign w_ovr_evt   = w_push & w_full & ~w_pop;
    assign w_ovwr      = w_ovr_evt & ~cfg_fifo_en_i;
    assign w_acc       = w_push & (~w_full | w_pop);

    // An overwrite in legacy mode replaces the head, so its error flag leaves with it.
    assign w_err_inc   = (w_acc | w_ovwr) & w_new_err;
    assign w_err_dec   = (w_pop | w_ovwr) & w_head_err;

    always_ff @(posedge clk_i) begin
        if (w_acc)
            r_mem[r_wr_ptr] <= {rx_err_i, rx_data_i};
        else if (w_ovwr)
            r_mem[r_rd_ptr] <= {rx_err_i, rx_data_i};
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_err_cnt <= '0;
        end else if (w_flush) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_err_cnt <= '0;
        end else begin
            r_wr_ptr  <= r_wr_ptr + AW'(w_acc);
            r_rd_ptr  <= r_rd_ptr + AW'(w_pop);
            r_count   <= r_count + CW'(w_acc) - CW'(w_pop);
            r_err_cnt <= r_err_cnt + CW'(w_err_inc) - CW'(w_err_dec);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_overrun <= 1'b0;
            r_en_q    <= 1'b0;
            r_en_vld  <= 1'b0;
        end else begin
            r_en_q   <= cfg_fifo_en_i;
            r_en_vld <= 1'b1;
            if (w_ovr_evt)
                r_overrun <= 1'b1;
            else if (ovr_clr_i)
                r_overrun <= 1'b0;
        end
    end

    // Character timeout: prescaler produces bit ticks, bit-time counter saturates.
    assign w_tmr_rst = w_flush | w_push | w_pop | ~w_valid;
    assign w_tick    = (r_pre >= cfg_div_i);
    assign w_pre_nxt = w_tick ? '0 : r_pre + 1'b1;
    assign w_bt_nxt  = (w_tick && r_bt != BT_MAX) ? r_bt + 6'd1 : r_bt;
    assign w_thr     = {cfg_frame_bits_i, 2'b00};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_pre     <= '0;
            r_bt      <= '0;
            r_timeout <= 1'b0;
        end else if (w_tmr_rst) begin
            r_pre     <= '0;
            r_bt      <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_pre <= w_pre_nxt;
            r_bt  <= w_bt_nxt;
            if (cfg_fifo_en_i && w_bt_nxt >= w_thr)
                r_timeout <= 1'b1;
        end
    end

    always_comb begin
        w_lvl = LVL_1;
        if (cfg_fifo_en_i) begin
            case (cfg_trigger_i)
                2'b00:   w_lvl = LVL_1;
                2'b01:   w_lvl = LVL_Q;
                2'b10:   w_lvl = LVL_H;
                default: w_lvl = LVL_M2;
            endcase
        end
    end

    assign valid_o    = w_valid;
    assign data_o     = w_head[7:0];
    assign err_o      = w_head[10:8];
    assign elements_o = r_count;
    assign overrun_o  = r_overrun;
    assign fifo_err_o = (r_err_cnt != '0);
    assign trigger_o  = w_valid & (r_count >= w_lvl);
    assign timeout_o  = r_timeout;
endmodule

// File: tb/tb_uart_rx_buffer.sv
// Randomized + directed bench for uart_rx_buffer against a queue-based reference model.
module tb_uart_rx_buffer;
    localparam int D  = 16;
    localparam int DW = 16;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic          cfg_fifo_en_i = 1'b1;
    logic [1:0]    cfg_trigger_i = 2'b00;
    logic [DW-1:0] cfg_div_i = 16'd3;
    logic [3:0]    cfg_frame_bits_i = 4'd10;
    logic          clr_i = 1'b0, rx_valid_i = 1'b0, pop_i = 1'b0, ovr_clr_i = 1'b0;
    logic [7:0]    rx_data_i = '0;
    logic [2:0]    rx_err_i = '0;
    logic          valid_o, overrun_o, fifo_err_o, trigger_o, timeout_o;
    logic [7:0]    data_o;
    logic [2:0]    err_o;
    logic [4:0]    elements_o;

    always #5 clk_i = ~clk_i;

    uart_rx_buffer #(.FIFO_DEPTH(D), .DIV_WIDTH(DW)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .cfg_fifo_en_i(cfg_fifo_en_i),
        .cfg_trigger_i(cfg_trigger_i), .cfg_div_i(cfg_div_i),
        .cfg_frame_bits_i(cfg_frame_bits_i), .clr_i(clr_i), .rx_valid_i(rx_valid_i),
        .rx_data_i(rx_data_i), .rx_err_i(rx_err_i), .pop_i(pop_i), .ovr_clr_i(ovr_clr_i),
        .valid_o(valid_o), .data_o(data_o), .err_o(err_o), .elements_o(elements_o),
        .overrun_o(overrun_o), .fifo_err_o(fifo_err_o), .trigger_o(trigger_o),
        .timeout_o(timeout_o)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of {err,data}, idle-clock count since last timer event.
    logic [10:0] q[$];
    bit          m_ovr, m_to, m_prev_en;
    int          m_idle;

    function automatic int m_level();
        if (!cfg_fifo_en_i) return 1;
        case (cfg_trigger_i)
            2'b00:   return 1;
            2'b01:   return D / 4;
            2'b10:   return D / 2;
            default: return D - 2;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovr = 0; m_to = 0; m_idle = 0;
        m_prev_en = cfg_fifo_en_i;
    endtask

    task automatic model_step();
        int  occ, depth, thr;
        bit  flush, pop_ok, full;
        occ   = q.size();
        depth = cfg_fifo_en_i ? D : 1;
        flush = clr_i || (cfg_fifo_en_i != m_prev_en);
        m_prev_en = cfg_fifo_en_i;
        if (flush) begin
            q.delete();
            m_idle = 0; m_to = 0;
            if (ovr_clr_i) m_ovr = 0;
            return;
        end
        pop_ok = pop_i && occ > 0;
        full   = (occ == depth);
        if (rx_valid_i && full && !pop_ok) m_ovr = 1;
        else if (ovr_clr_i) m_ovr = 0;
        if (pop_ok) void'(q.pop_front());
        if (rx_valid_i) begin
            if (full && !pop_ok) begin
                if (!cfg_fifo_en_i) q[0] = {rx_err_i, rx_data_i};
            end else q.push_back({rx_err_i, rx_data_i});
        end
        if (rx_valid_i || pop_ok || occ == 0) begin
            m_idle = 0; m_to = 0;
        end else begin
            m_idle++;
            thr = (int'(cfg_div_i) + 1) * 4 * int'(cfg_frame_bits_i);
            if (cfg_fifo_en_i && m_idle >= thr) m_to = 1;
        end
    endtask

    task automatic check_all();
        bit any_err = 0;
        foreach (q[i]) if (q[i][10:8] != 0) any_err = 1;
        chk("valid", valid_o, q.size() > 0);
        if (q.size() > 0) begin
            chk("data", data_o, q[0][7:0]);
            chk("err", err_o, q[0][10:8]);
        end
        chk("elements", elements_o, q.size());
        chk("overrun", overrun_o, m_ovr);
        chk("fifo_err", fifo_err_o, any_err);
        chk("trigger", trigger_o, q.size() > 0 && q.size() >= m_level());
        chk("timeout", timeout_o, m_to);
    endtask

    task automatic step();
        @(posedge clk_i);
        model_step();
        #1;
        check_all();
        rx_valid_i = 0; pop_i = 0; clr_i = 0; ovr_clr_i = 0;
    endtask

    task automatic push(input logic [7:0] d, input logic [2:0] e);
        rx_valid_i = 1; rx_data_i = d; rx_err_i = e;
        step();
    endtask

    task automatic pop();
        pop_i = 1;
        step();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rstn_i = 0;
        #1;
        model_reset();
        chk("rst_valid", valid_o, 0);
        chk("rst_elements", elements_o, 0);
        chk("rst_overrun", overrun_o, 0);
        chk("rst_fifo_err", fifo_err_o, 0);
        chk("rst_trigger", trigger_o, 0);
        chk("rst_timeout", timeout_o, 0);
        @(negedge clk_i);
        rstn_i = 1;
        model_reset();
    endtask

    initial begin
        int k;
        do_reset();

        // Fill to full, overrun drop, drain in order.
        for (int i = 0; i < 16; i++) push(8'(i), 3'b000);
        chk("s31_elems", elements_o, 16);
        push(8'hAA, 3'b000);
        chk("s31_ovr", overrun_o, 1);
        chk("s31_elems_after", elements_o, 16);
        for (int i = 0; i < 16; i++) begin
            chk("s31_head", data_o, 8'(i));
            pop();
        end
        chk("s31_empty", valid_o, 0);
        ovr_clr_i = 1; step();
        chk("ovr_clr", overrun_o, 0);

        // Trigger level at half depth.
        cfg_trigger_i = 2'b10;
        for (int i = 0; i < 7; i++) push(8'(8'h30 + i), 3'b000);
        chk("s32_trig7", trigger_o, 0);
        push(8'h37, 3'b000);
        chk("s32_trig8", trigger_o, 1);
        pop();
        chk("s32_trig_pop", trigger_o, 0);
        clr_i = 1; step();
        cfg_trigger_i = 2'b00;

        // Character timeout latency.
        cfg_div_i = 16'd3; cfg_frame_bits_i = 4'd10;
        push(8'h5A, 3'b000);
        k = 0;
        while (!timeout_o && k <= 400) begin
            step();
            k++;
        end
        chk("s33_latency", k, 160);
        pop();
        chk("s33_to_clear", timeout_o, 0);

        // Error summary follows the entries.
        push(8'h55, 3'b001);
        push(8'h66, 3'b000);
        chk("s34_err_set", fifo_err_o, 1);
        pop();
        chk("s34_err_clr", fifo_err_o, 0);
        pop();

        // Legacy holding register overwrite.
        cfg_fifo_en_i = 0; step();
        push(8'h11, 3'b000);
        push(8'h22, 3'b000);
        chk("s35_elems", elements_o, 1);
        chk("s35_data", data_o, 8'h22);
        chk("s35_ovr", overrun_o, 1);
        ovr_clr_i = 1; step();
        chk("s35_ovr_clr", overrun_o, 0);
        cfg_fifo_en_i = 1; step();
        chk("mode_flush", elements_o, 0);

        // Full FIFO push+pop, then clear with a same-cycle push.
        for (int i = 0; i < 16; i++) push(8'(8'h80 + i), 3'b000);
        rx_valid_i = 1; rx_data_i = 8'hEE; rx_err_i = 0; pop_i = 1; step();
        chk("s36_elems", elements_o, 16);
        chk("s36_ovr", overrun_o, 0);
        clr_i = 1; rx_valid_i = 1; rx_data_i = 8'h77; step();
        chk("s36_clr_elems", elements_o, 0);
        chk("s36_clr_valid", valid_o, 0);

        // Reset mid-operation, then normal resume.
        push(8'h01, 3'b100); push(8'h02, 3'b000);
        do_reset();
        push(8'h03, 3'b010);
        chk("post_rst_data", data_o, 8'h03);
        pop();

        // Randomized blocks; timer settings change only together with a clear.
        for (int b = 0; b < 12; b++) begin
            int pp, pq;
            cfg_fifo_en_i    = ($urandom % 4) != 0;
            cfg_trigger_i    = 2'($urandom);
            cfg_div_i        = DW'($urandom % 3);
            cfg_frame_bits_i = 4'(7 + $urandom % 6);
            pp = 1 + $urandom % 6;
            pq = 1 + $urandom % 6;
            clr_i = 1; step();
            for (int c = 0; c < 300; c++) begin
                rx_valid_i = ($urandom % 16) < pp;
                rx_data_i  = 8'($urandom);
                rx_err_i   = (($urandom % 4) == 0) ? 3'($urandom) : 3'b000;
                pop_i      = ($urandom % 16) < pq;
                ovr_clr_i  = ($urandom % 16) == 0;
                clr_i      = ($urandom % 200) == 0;
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
